if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch_pkg.sv | 30 +++
 rtl/if_fetch_icache.sv | 45 ++++
 rtl/if_fetch.sv | 151 +++++++++++++++
 tb/tb_if_fetch.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared constants and types for the instruction fetch slice.
//   NOP            - instruction presented whenever no valid fetch is held
//   state_e        - fetch FSM encoding (IDLE, FETCH, HOLD)
//   AddrLen/InstLen- address and instruction widths
//   IdxW/TagW      - icache index/tag widths (index pc[7:2], tag pc[31:8])
package if_fetch_pkg;

    localparam int AddrLen = 32;
    localparam int InstLen = 32;
    localparam int IdxW    = 6;
    localparam int TagW    = 24;
    localparam int Lines   = 64;

    localparam logic [InstLen-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

    function automatic logic [IdxW-1:0] pc_idx(input logic [AddrLen-1:0] pc);
        return pc[7:2];
    endfunction

    function automatic logic [TagW-1:0] pc_tag(input logic [AddrLen-1:0] pc);
        return pc[31:8];
    endfunction

endpackage

// File: rtl/if_fetch_icache.sv
// if_icache: 64-line direct-mapped instruction cache storage (built only with
// ICACHE_EN). Combinational lookup, single-cycle line fill.
//   clk, rst      - clock, synchronous active-high reset (clears valid bits)
//   idx_i, tag_i  - lookup/fill index and tag
//   hit_o, data_o - lookup result
//   fill_i        - write fill_data_i into line idx_i with tag tag_i
module if_icache
    import if_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [IdxW-1:0]    idx_i,
    input  logic [TagW-1:0]    tag_i,
    output logic               hit_o,
    output logic [InstLen-1:0] data_o,
    input  logic               fill_i,
    input  logic [InstLen-1:0] fill_data_i
);

    logic [Lines-1:0]   vld_q, vld_d;
    logic [TagW-1:0]    tag_q  [Lines];
    logic [InstLen-1:0] data_q [Lines];

    assign hit_o  = vld_q[idx_i] && (tag_q[idx_i] == tag_i);
    assign data_o = data_q[idx_i];

    always_comb begin
        vld_d = vld_q;
        if (fill_i) vld_d[idx_i] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) vld_q <= '0;
        else     vld_q <= vld_d;
    end

    // Tag/data need no reset: a line is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (fill_i) begin
            tag_q[idx_i]  <= tag_i;
            data_q[idx_i] <= fill_data_i;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// if_fetch: byte-serial instruction fetch. Issues up to four byte reads at
// pc..pc+3, assembles them little-endian and holds the word for IF/ID until
// released, then advances pc by 4. EX redirects override everything.
//   clk, rst (sync, active-high), rdy_i (global enable)
//   stall_i, br_flag_i, br_target_i      - pipeline control
//   mem_req_o/mem_addr_o, mem_busy_i     - byte request port
//   mem_byte_i/mem_byte_vld_i            - byte return (one cycle after request)
//   pc_o, inst_o, inst_vld_o, stall_if_o - to IF/ID and stall_ctrl
// Optional feature: define ICACHE_EN to add the if_icache line store.
module if_fetch
    import if_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy_i,
    input  logic               stall_i,
    input  logic               br_flag_i,
    input  logic [AddrLen-1:0] br_target_i,
    input  logic               mem_busy_i,
    output logic               mem_req_o,
    output logic [AddrLen-1:0] mem_addr_o,
    input  logic [7:0]         mem_byte_i,
    input  logic               mem_byte_vld_i,
    output logic [AddrLen-1:0] pc_o,
    output logic [InstLen-1:0] inst_o,
    output logic               inst_vld_o,
    output logic               stall_if_o
);

    state_e             state_q, state_d;
    logic [AddrLen-1:0] pc_q, pc_d;
    logic [InstLen-1:0] inst_q, inst_d;
    logic [2:0]         iss_q, iss_d, rcv_q, rcv_d;
    logic               vld_q, vld_d;
    logic               disc_q, disc_d;

    logic               hit;
    logic [InstLen-1:0] hit_data;
    logic               in_fetch, hit_now, issue, take, last;

    assign in_fetch = (state_q == S_FETCH);
    assign hit_now  = in_fetch && (iss_q == 3'd0) && hit;
    assign issue    = rdy_i && in_fetch && (iss_q < 3'd4) && !mem_busy_i && !hit_now;
    // disc_q drops the byte answering a request issued in the redirect cycle.
    assign take     = in_fetch && mem_byte_vld_i && !disc_q && (rcv_q < 3'd4);
    assign last     = take && (rcv_q == 3'd3);

`ifdef ICACHE_EN
    logic fill;
    assign fill = rdy_i && !br_flag_i && last;

    if_icache u_icache (
        .clk         (clk),
        .rst         (rst),
        .idx_i       (pc_idx(pc_q)),
        .tag_i       (pc_tag(pc_q)),
        .hit_o       (hit),
        .data_o      (hit_data),
        .fill_i      (fill),
        .fill_data_i ({mem_byte_i, inst_q[23:0]})
    );
`else
    assign hit      = 1'b0;
    assign hit_data = NOP;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        iss_d   = iss_q;
        rcv_d   = rcv_q;
        vld_d   = vld_q;
        disc_d  = disc_q;
        if (rdy_i) begin
            disc_d = 1'b0;
            if (br_flag_i) begin
                state_d = S_FETCH;
                pc_d    = br_target_i;
                iss_d   = '0;
                rcv_d   = '0;
                vld_d   = 1'b0;
                disc_d  = 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        state_d = S_FETCH;
                        iss_d   = '0;
                        rcv_d   = '0;
                    end
                    S_FETCH: begin
                        if (hit_now) begin
                            inst_d  = hit_data;
                            vld_d   = 1'b1;
                            state_d = S_HOLD;
                        end else begin
                            if (issue) iss_d = iss_q + 3'd1;
                            if (take) begin
                                inst_d[{rcv_q[1:0], 3'b000} +: 8] = mem_byte_i;
                                rcv_d = rcv_q + 3'd1;
                            end
                            if (last) begin
                                vld_d   = 1'b1;
                                state_d = S_HOLD;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (!stall_i) begin
                            state_d = S_FETCH;
                            pc_d    = pc_q + 32'd4;
                            iss_d   = '0;
                            rcv_d   = '0;
                            vld_d   = 1'b0;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            inst_q  <= NOP;
            iss_q   <= '0;
            rcv_q   <= '0;
            vld_q   <= 1'b0;
            disc_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            iss_q   <= iss_d;
            rcv_q   <= rcv_d;
            vld_q   <= vld_d;
            disc_q  <= disc_d;
        end
    end

    // Outputs are forced to their idle values while rst is asserted.
    assign mem_req_o  = !rst && issue;
    assign mem_addr_o = rst ? '0 : pc_q + AddrLen'(iss_q);
    assign pc_o       = rst ? '0 : pc_q;
    assign inst_vld_o = !rst && vld_q;
    assign inst_o     = inst_vld_o ? inst_q : NOP;
    assign stall_if_o = !rst && !vld_q;

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst, rdy_i, stall_i, br_flag_i, mem_busy_i;
    logic [31:0] br_target_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [7:0]  mem_byte_i;
    logic        mem_byte_vld_i;
    logic [31:0] pc_o, inst_o;
    logic        inst_vld_o, stall_if_o;

    logic [7:0]  mem [512];
    logic [31:0] alog [$];
    int          checks = 0;
    int          errors = 0;
    int          n0;

    always #5 clk = ~clk;

    if_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .rdy_i          (rdy_i),
        .stall_i        (stall_i),
        .br_flag_i      (br_flag_i),
        .br_target_i    (br_target_i),
        .mem_busy_i     (mem_busy_i),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_byte_i     (mem_byte_i),
        .mem_byte_vld_i (mem_byte_vld_i),
        .pc_o           (pc_o),
        .inst_o         (inst_o),
        .inst_vld_o     (inst_vld_o),
        .stall_if_o     (stall_if_o)
    );

    // One clock: sample the request just before the edge, then answer it
    // (one cycle later) right after the edge.
    task automatic tick(input int n = 1);
        logic        pend;
        logic [31:0] pa;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pend = mem_req_o;
            pa   = mem_addr_o;
            if (pend) alog.push_back(pa);
            @(posedge clk);
            #1;
            mem_byte_vld_i = pend;
            mem_byte_i     = pend ? mem[pa[8:0]] : 8'h00;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        foreach (mem[i]) mem[i] = 8'h00;
        {mem[3],   mem[2],   mem[1],   mem[0]}   = 32'h0010_0513;
        {mem[7],   mem[6],   mem[5],   mem[4]}   = 32'h0020_0593;
        {mem[11],  mem[10],  mem[9],   mem[8]}   = 32'h0030_0613;
        {mem[35],  mem[34],  mem[33],  mem[32]}  = 32'h0040_0713;
        {mem[259], mem[258], mem[257], mem[256]} = 32'h00c5_86b3;
        {mem[511], mem[510], mem[509], mem[508]} = 32'h0000_1237;

        rst = 1'b1; rdy_i = 1'b1; stall_i = 1'b0; br_flag_i = 1'b0;
        br_target_i = '0; mem_busy_i = 1'b0; mem_byte_i = '0; mem_byte_vld_i = 1'b0;

        // reset state
        tick(2);
        chk("rst_pc",    pc_o, 32'h0);
        chk("rst_inst",  inst_o, 32'h13);
        chk("rst_vld",   32'(inst_vld_o), 32'h0);
        chk("rst_stall", 32'(stall_if_o), 32'h0);
        chk("rst_addr",  mem_addr_o, 32'h0);
        chk("rst_nreq",  32'(alog.size()), 32'h0);

        // first fetch at pc 0: HOLD 5 cycles after FETCH entry
        rst = 1'b0;
        tick(1);
        chk("fe_stall", 32'(stall_if_o), 32'h1);
        chk("fe_nop",   inst_o, 32'h13);
        tick(4);
        chk("lat_early", 32'(inst_vld_o), 32'h0);
        tick(1);
        chk("f0_vld",   32'(inst_vld_o), 32'h1);
        chk("f0_inst",  inst_o, 32'h0010_0513);
        chk("f0_pc",    pc_o, 32'h0);
        chk("f0_stall", 32'(stall_if_o), 32'h0);
        chk("f0_nreq",  32'(alog.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("f0_addr", alog[i], 32'(i));

        // stall in HOLD for 4 cycles
        stall_i = 1'b1;
        n0 = alog.size();
        tick(4);
        chk("st_pc",   pc_o, 32'h0);
        chk("st_inst", inst_o, 32'h0010_0513);
        chk("st_vld",  32'(inst_vld_o), 32'h1);
        chk("st_nreq", 32'(alog.size()), 32'(n0));
        stall_i = 1'b0;
        tick(1);
        chk("adv_pc",  pc_o, 32'h4);
        chk("adv_vld", 32'(inst_vld_o), 32'h0);
        chk("adv_nop", inst_o, 32'h13);

        // memory busy for the first 3 FETCH cycles
        mem_busy_i = 1'b1;
        tick(3);
        mem_busy_i = 1'b0;
        chk("busy_nreq", 32'(alog.size()), 32'(n0));
        tick(4);
        chk("busy_early", 32'(inst_vld_o), 32'h0);
        tick(1);
        chk("busy_vld",  32'(inst_vld_o), 32'h1);
        chk("busy_inst", inst_o, 32'h0020_0593);
        chk("busy_pc",   pc_o, 32'h4);
        chk("busy_nreq2", 32'(alog.size()), 32'(n0 + 4));
        for (int i = 0; i < 4; i++) chk("busy_addr", alog[n0 + i], 32'(4 + i));

        // redirect and stall together in HOLD: redirect wins
        stall_i = 1'b1; br_flag_i = 1'b1; br_target_i = 32'h8;
        tick(1);
        br_flag_i = 1'b0; stall_i = 1'b0;
        chk("bs_pc",  pc_o, 32'h8);
        chk("bs_vld", 32'(inst_vld_o), 32'h0);

        // redirect mid-fetch with two bytes received
        n0 = alog.size();
        tick(3);
        br_flag_i = 1'b1; br_target_i = 32'h100;
        tick(1);
        br_flag_i = 1'b0;
        chk("br_pc",  pc_o, 32'h100);
        chk("br_vld", 32'(inst_vld_o), 32'h0);
        tick(1);
        chk("br_addr", alog[n0 + 4], 32'h100);
        tick(3);
        chk("disc_early", 32'(inst_vld_o), 32'h0);
        tick(1);
        chk("br_done", 32'(inst_vld_o), 32'h1);
        chk("br_inst", inst_o, 32'h00c5_86b3);
        chk("br_pc2",  pc_o, 32'h100);
        chk("br_nreq", 32'(alog.size()), 32'(n0 + 8));

        // rdy_i low freezes a fetch and blocks requests
        tick(1);
        chk("rdy_pc0", pc_o, 32'h104);
        rdy_i = 1'b0;
        n0 = alog.size();
        tick(2);
        chk("rdy_nreq", 32'(alog.size()), 32'(n0));
        chk("rdy_pc",   pc_o, 32'h104);
        chk("rdy_vld",  32'(inst_vld_o), 32'h0);
        rdy_i = 1'b1;
        tick(1);
        chk("rdy_addr", alog[n0], 32'h104);

        // reset mid-fetch, then clean refetch of pc 0
        tick(1);
        rst = 1'b1;
        tick(1);
        chk("mr_pc",    pc_o, 32'h0);
        chk("mr_inst",  inst_o, 32'h13);
        chk("mr_vld",   32'(inst_vld_o), 32'h0);
        chk("mr_stall", 32'(stall_if_o), 32'h0);
        rst = 1'b0;
        n0 = alog.size();
        tick(6);
        chk("mr_vld2",  32'(inst_vld_o), 32'h1);
        chk("mr_inst2", inst_o, 32'h0010_0513);
        chk("mr_nreq",  32'(alog.size()), 32'(n0 + 4));
        chk("mr_addr",  alog[n0], 32'h0);

        // pc wrap from 0xFFFFFFFC
        br_flag_i = 1'b1; br_target_i = 32'hFFFF_FFFC;
        tick(1);
        br_flag_i = 1'b0;
        chk("wr_pc", pc_o, 32'hFFFF_FFFC);
        tick(5);
        chk("wr_vld",  32'(inst_vld_o), 32'h1);
        chk("wr_inst", inst_o, 32'h0000_1237);
        chk("wr_last", alog[alog.size() - 1], 32'hFFFF_FFFF);
        tick(1);
        chk("wr_pc0", pc_o, 32'h0);
        chk("wr_vld0", 32'(inst_vld_o), 32'h0);
`ifdef ICACHE_EN
        n0 = alog.size();
        tick(1);
        chk("ic_hit0_vld",  32'(inst_vld_o), 32'h1);
        chk("ic_hit0_inst", inst_o, 32'h0010_0513);
        chk("ic_hit0_nreq", 32'(alog.size()), 32'(n0));
        br_flag_i = 1'b1; br_target_i = 32'h20;
        tick(1);
        br_flag_i = 1'b0;
        tick(5);
        chk("ic_miss_inst", inst_o, 32'h0040_0713);
        br_flag_i = 1'b1;
        tick(1);
        br_flag_i = 1'b0;
        n0 = alog.size();
        tick(1);
        chk("ic_hit_vld",  32'(inst_vld_o), 32'h1);
        chk("ic_hit_inst", inst_o, 32'h0040_0713);
        chk("ic_hit_nreq", 32'(alog.size()), 32'(n0));
`else
        tick(5);
        chk("wr_vld2",  32'(inst_vld_o), 32'h1);
        chk("wr_inst2", inst_o, 32'h0010_0513);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
